// File: rtl/mipi_csi_rx_packet_ctrl_pkg.sv
// Shared constants and types for the CSI-2 RX packet controller:
// data-type codes, data-ID field positions and the packet FSM states.
package mipi_csi_rx_pkg;

  localparam logic [5:0] DT_FS         = 6'h00;
  localparam logic [5:0] DT_FE         = 6'h01;
  localparam logic [5:0] DT_LS         = 6'h02;
  localparam logic [5:0] DT_LE         = 6'h03;
  localparam logic [5:0] SHORT_PKT_MAX = 6'h0F;

  localparam int DI_VC_MSB = 7;
  localparam int DI_VC_LSB = 6;
  localparam int DI_DT_MSB = 5;
  localparam int DI_DT_LSB = 0;

  typedef enum logic [1:0] {
    ST_WAIT_HDR = 2'd0,
    ST_PAYLOAD  = 2'd1,
    ST_CRC_WAIT = 2'd2,
    ST_SKIP     = 2'd3
  } pkt_state_e;

  function automatic logic is_short_dt(input logic [5:0] dt);
    return dt <= SHORT_PKT_MAX;
  endfunction

endpackage

// File: rtl/mipi_csi_rx_sat_counter.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones,
// clears only on reset.
module mipi_csi_rx_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mipi_csi_rx_packet_ctrl.sv
// CSI-2 RX packet sequencer: header decode, payload gating, frame/line tracking
// and error reporting. Define MIPI_CSI_RX_PKT_TIMEOUT_EN to add a progress watchdog.
module mipi_csi_rx_packet_ctrl
  import mipi_csi_rx_pkg::*;
#(
  parameter int ERR_CNT_W      = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 enable_i,
  input  logic [2:0]           active_lanes_i,
  input  logic [1:0]           vc_select_i,
  input  logic                 hdr_valid_i,
  input  logic [7:0]           hdr_data_id_i,
  input  logic [15:0]          hdr_word_count_i,
  input  logic                 hdr_ecc_err_i,
  input  logic                 hdr_ecc_corr_i,
  input  logic                 payload_valid_i,
  input  logic [2:0]           payload_bytes_i,
  input  logic                 crc_done_i,
  input  logic                 crc_err_i,
  input  logic                 eot_i,
  output logic                 payload_en_o,
  output logic                 payload_last_o,
  output logic [5:0]           pixel_dt_o,
  output logic                 frame_valid_o,
  output logic                 line_valid_o,
  output logic [15:0]          frame_num_o,
  output logic [15:0]          line_num_o,
  output logic                 pkt_done_o,
  output logic                 err_ecc_o,
  output logic                 err_crc_o,
  output logic                 err_sync_o,
  output logic                 err_trunc_o,
  output logic [ERR_CNT_W-1:0] err_ecc_cnt_o,
  output logic [ERR_CNT_W-1:0] err_crc_cnt_o
);

  pkt_state_e  state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [5:0]  dt_q, dt_d;
  logic        frame_valid_q, frame_valid_d;
  logic        line_valid_q, line_valid_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic [15:0] line_num_q, line_num_d;
  logic        pkt_done_q, pkt_done_d;
  logic        err_ecc_q, err_ecc_d;
  logic        err_crc_q, err_crc_d;
  logic        err_sync_q, err_sync_d;
  logic        err_trunc_q, err_trunc_d;
  logic        ecc_inc, crc_inc, last_beat;

  logic [1:0]  hdr_vc;
  logic [5:0]  hdr_dt;
  logic [2:0]  beat_bytes;
  logic        beat_final;

  assign hdr_vc     = hdr_data_id_i[DI_VC_MSB:DI_VC_LSB];
  assign hdr_dt     = hdr_data_id_i[DI_DT_MSB:DI_DT_LSB];
  // A beat can never carry more bytes than there are active lanes.
  assign beat_bytes = (payload_bytes_i > active_lanes_i) ? active_lanes_i : payload_bytes_i;
  assign beat_final = ({13'd0, beat_bytes} >= remaining_q);

`ifdef MIPI_CSI_RX_PKT_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    dt_d          = dt_q;
    frame_valid_d = frame_valid_q;
    line_valid_d  = line_valid_q;
    frame_num_d   = frame_num_q;
    line_num_d    = line_num_q;
    pkt_done_d    = 1'b0;
    err_ecc_d     = 1'b0;
    err_crc_d     = 1'b0;
    err_sync_d    = 1'b0;
    err_trunc_d   = 1'b0;
    ecc_inc       = 1'b0;
    crc_inc       = 1'b0;
    last_beat     = 1'b0;

    if (!enable_i) begin
      state_d = ST_WAIT_HDR;
    end else begin
      unique case (state_q)
        ST_WAIT_HDR: begin
          if (hdr_valid_i) begin
            ecc_inc = hdr_ecc_err_i | hdr_ecc_corr_i;
            if (hdr_ecc_err_i) begin
              err_ecc_d = 1'b1;
              state_d   = ST_SKIP;
            end else if (hdr_vc != vc_select_i) begin
              if (!is_short_dt(hdr_dt)) state_d = ST_SKIP;
            end else if (is_short_dt(hdr_dt)) begin
              if (hdr_dt == DT_FS) begin
                err_sync_d    = frame_valid_q;
                frame_valid_d = 1'b1;
                frame_num_d   = hdr_word_count_i;
                line_num_d    = '0;
              end else if (hdr_dt == DT_FE) begin
                err_sync_d    = !frame_valid_q;
                frame_valid_d = 1'b0;
                line_valid_d  = 1'b0;
              end else if (hdr_dt == DT_LS) begin
                if (frame_valid_q) line_valid_d = 1'b1;
                else               err_sync_d   = 1'b1;
              end else if (hdr_dt == DT_LE) begin
                line_valid_d = 1'b0;
              end
            end else begin
              remaining_d = hdr_word_count_i;
              dt_d        = hdr_dt;
              state_d     = (hdr_word_count_i == '0) ? ST_CRC_WAIT : ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          // A truncating eot wins over a beat arriving in the same cycle.
          if (eot_i) begin
            err_trunc_d  = 1'b1;
            line_valid_d = 1'b0;
            state_d      = ST_WAIT_HDR;
          end else if (payload_valid_i) begin
            if (beat_final) begin
              last_beat   = 1'b1;
              remaining_d = '0;
              state_d     = ST_CRC_WAIT;
            end else begin
              remaining_d = remaining_q - {13'd0, beat_bytes};
            end
          end
        end
        ST_CRC_WAIT: begin
          if (eot_i) begin
            err_trunc_d  = 1'b1;
            line_valid_d = 1'b0;
            state_d      = ST_WAIT_HDR;
          end else if (crc_done_i) begin
            pkt_done_d = 1'b1;
            err_crc_d  = crc_err_i;
            crc_inc    = crc_err_i;
            if (frame_valid_q) line_num_d = line_num_q + 16'd1;
            state_d    = ST_WAIT_HDR;
          end
        end
        ST_SKIP: begin
          if (eot_i) state_d = ST_WAIT_HDR;
        end
        default: state_d = ST_WAIT_HDR;
      endcase
    end

`ifdef MIPI_CSI_RX_PKT_TIMEOUT_EN
    wd_d = '0;
    if (enable_i && (state_q != ST_WAIT_HDR) && (state_d != ST_WAIT_HDR) &&
        !payload_valid_i && !crc_done_i) begin
      if (wd_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        err_trunc_d  = 1'b1;
        line_valid_d = 1'b0;
        state_d      = ST_WAIT_HDR;
      end else begin
        wd_d = wd_q + 32'd1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_WAIT_HDR;
      remaining_q   <= '0;
      dt_q          <= '0;
      frame_valid_q <= 1'b0;
      line_valid_q  <= 1'b0;
      frame_num_q   <= '0;
      line_num_q    <= '0;
      pkt_done_q    <= 1'b0;
      err_ecc_q     <= 1'b0;
      err_crc_q     <= 1'b0;
      err_sync_q    <= 1'b0;
      err_trunc_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      dt_q          <= dt_d;
      frame_valid_q <= frame_valid_d;
      line_valid_q  <= line_valid_d;
      frame_num_q   <= frame_num_d;
      line_num_q    <= line_num_d;
      pkt_done_q    <= pkt_done_d;
      err_ecc_q     <= err_ecc_d;
      err_crc_q     <= err_crc_d;
      err_sync_q    <= err_sync_d;
      err_trunc_q   <= err_trunc_d;
    end
  end

`ifdef MIPI_CSI_RX_PKT_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`endif

  mipi_csi_rx_sat_counter #(.W(ERR_CNT_W)) u_ecc_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (ecc_inc),
    .count_o (err_ecc_cnt_o)
  );

  mipi_csi_rx_sat_counter #(.W(ERR_CNT_W)) u_crc_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (crc_inc),
    .count_o (err_crc_cnt_o)
  );

  assign payload_en_o   = enable_i && (state_q == ST_PAYLOAD);
  assign payload_last_o = last_beat;
  assign pixel_dt_o     = dt_q;
  assign frame_valid_o  = frame_valid_q;
  assign line_valid_o   = line_valid_q;
  assign frame_num_o    = frame_num_q;
  assign line_num_o     = line_num_q;
  assign pkt_done_o     = pkt_done_q;
  assign err_ecc_o      = err_ecc_q;
  assign err_crc_o      = err_crc_q;
  assign err_sync_o     = err_sync_q;
  assign err_trunc_o    = err_trunc_q;

endmodule

// File: tb/tb_mipi_csi_rx_packet_ctrl.sv
// Self-checking bench for mipi_csi_rx_packet_ctrl: directed scenarios plus a
// randomized packet mix, checked against a packet-level reference model.
module tb_mipi_csi_rx_packet_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i, enable_i;
  logic [2:0]  active_lanes_i;
  logic [1:0]  vc_select_i;
  logic        hdr_valid_i;
  logic [7:0]  hdr_data_id_i;
  logic [15:0] hdr_word_count_i;
  logic        hdr_ecc_err_i, hdr_ecc_corr_i;
  logic        payload_valid_i;
  logic [2:0]  payload_bytes_i;
  logic        crc_done_i, crc_err_i, eot_i;
  logic        payload_en_o, payload_last_o;
  logic [5:0]  pixel_dt_o;
  logic        frame_valid_o, line_valid_o;
  logic [15:0] frame_num_o, line_num_o;
  logic        pkt_done_o;
  logic        err_ecc_o, err_crc_o, err_sync_o, err_trunc_o;
  logic [15:0] err_ecc_cnt_o, err_crc_cnt_o;

  mipi_csi_rx_packet_ctrl dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .active_lanes_i(active_lanes_i), .vc_select_i(vc_select_i),
    .hdr_valid_i(hdr_valid_i), .hdr_data_id_i(hdr_data_id_i),
    .hdr_word_count_i(hdr_word_count_i), .hdr_ecc_err_i(hdr_ecc_err_i),
    .hdr_ecc_corr_i(hdr_ecc_corr_i), .payload_valid_i(payload_valid_i),
    .payload_bytes_i(payload_bytes_i), .crc_done_i(crc_done_i),
    .crc_err_i(crc_err_i), .eot_i(eot_i),
    .payload_en_o(payload_en_o), .payload_last_o(payload_last_o),
    .pixel_dt_o(pixel_dt_o), .frame_valid_o(frame_valid_o),
    .line_valid_o(line_valid_o), .frame_num_o(frame_num_o),
    .line_num_o(line_num_o), .pkt_done_o(pkt_done_o),
    .err_ecc_o(err_ecc_o), .err_crc_o(err_crc_o), .err_sync_o(err_sync_o),
    .err_trunc_o(err_trunc_o), .err_ecc_cnt_o(err_ecc_cnt_o),
    .err_crc_cnt_o(err_crc_cnt_o)
  );

  // Clock and global time bound.
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  // Reference model: protocol-visible state of the receiver.
  bit          m_fv, m_lv;
  logic [15:0] m_fn, m_ln, m_ecc, m_crc;
  logic [5:0]  m_dt;
  logic [1:0]  m_vc_sel;
  logic [5:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_frame_valid"}, 32'(frame_valid_o), 32'(m_fv));
    chk({tag, "_line_valid"},  32'(line_valid_o),  32'(m_lv));
    chk({tag, "_frame_num"},   32'(frame_num_o),   32'(m_fn));
    chk({tag, "_line_num"},    32'(line_num_o),    32'(m_ln));
  endtask

  // Driver: one header strobe; model applies the header rules, then outputs are checked.
  task automatic do_hdr(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                        input bit ecc_err, input bit ecc_corr);
    bit e_sync;
    e_sync = 1'b0;
    @(negedge clk_i);
    hdr_valid_i = 1'b1; hdr_data_id_i = {vc, dt}; hdr_word_count_i = wc;
    hdr_ecc_err_i = ecc_err; hdr_ecc_corr_i = ecc_corr;
    @(negedge clk_i);
    hdr_valid_i = 1'b0; hdr_ecc_err_i = 1'b0; hdr_ecc_corr_i = 1'b0;
    if ((ecc_err || ecc_corr) && m_ecc != 16'hFFFF) m_ecc = m_ecc + 16'd1;
    if (!ecc_err && vc == m_vc_sel) begin
      if (dt < 6'h10) begin
        case (dt)
          6'h00: begin e_sync = m_fv; m_fv = 1'b1; m_fn = wc; m_ln = 16'd0; end
          6'h01: begin e_sync = !m_fv; m_fv = 1'b0; m_lv = 1'b0; end
          6'h02: begin if (m_fv) m_lv = 1'b1; else e_sync = 1'b1; end
          6'h03: m_lv = 1'b0;
          default: ;
        endcase
      end else begin
        m_dt = dt;
        exp_q.push_back(dt);
      end
    end
    chk("hdr_err_ecc",  32'(err_ecc_o),     32'(ecc_err));
    chk("hdr_err_sync", 32'(err_sync_o),    32'(e_sync));
    chk("hdr_ecc_cnt",  32'(err_ecc_cnt_o), 32'(m_ecc));
    chk("hdr_pixel_dt", 32'(pixel_dt_o),    32'(m_dt));
    check_frame("hdr");
  endtask

  task automatic beat(input logic [2:0] b, input bit eot, input bit exp_en, input bit exp_last);
    @(negedge clk_i);
    payload_valid_i = 1'b1; payload_bytes_i = b; eot_i = eot;
    #1;
    chk("beat_payload_en",   32'(payload_en_o),   32'(exp_en));
    chk("beat_payload_last", 32'(payload_last_o), 32'(exp_last));
  endtask

  task automatic end_beats();
    @(negedge clk_i);
    payload_valid_i = 1'b0; eot_i = 1'b0;
  endtask

  // Long packet on the selected VC; fixed=0 gives random 1..4 byte beats.
  task automatic send_long(input logic [2:0] lanes, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [2:0] fixed, input bit corr);
    int sum;
    int b, eff;
    active_lanes_i = lanes;
    do_hdr(m_vc_sel, dt, wc, 1'b0, corr);
    sum = 0;
    while (sum < int'(wc)) begin
      if (fixed != 0) b = (int'(wc) - sum < int'(fixed)) ? int'(wc) - sum : int'(fixed);
      else            b = int'($urandom_range(1, 4));
      eff = (b > int'(lanes)) ? int'(lanes) : b;
      sum += eff;
      beat(3'(b), 1'b0, 1'b1, sum >= int'(wc));
    end
    if (wc != 16'd0) begin
      end_beats();
      chk("crc_wait_payload_en", 32'(payload_en_o), 32'd0);
    end
  endtask

  task automatic finish_crc(input bit crc_err);
    logic [5:0] exp_dt;
    @(negedge clk_i);
    crc_done_i = 1'b1; crc_err_i = crc_err;
    @(negedge clk_i);
    crc_done_i = 1'b0; crc_err_i = 1'b0;
    if (m_fv) m_ln = m_ln + 16'd1;
    if (crc_err && m_crc != 16'hFFFF) m_crc = m_crc + 16'd1;
    exp_dt = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h3F;
    chk("crc_pkt_done",  32'(pkt_done_o),    32'd1);
    chk("crc_err_crc",   32'(err_crc_o),     32'(crc_err));
    chk("crc_err_trunc", 32'(err_trunc_o),   32'd0);
    chk("crc_cnt",       32'(err_crc_cnt_o), 32'(m_crc));
    chk("crc_pixel_dt",  32'(pixel_dt_o),    32'(exp_dt));
    check_frame("crc");
  endtask

  task automatic do_eot(input bit exp_trunc);
    @(negedge clk_i);
    eot_i = 1'b1;
    @(negedge clk_i);
    eot_i = 1'b0;
    if (exp_trunc) m_lv = 1'b0;
    chk("eot_err_trunc", 32'(err_trunc_o), 32'(exp_trunc));
    chk("eot_pkt_done",  32'(pkt_done_o),  32'd0);
    check_frame("eot");
  endtask

  task automatic drop_expected();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  logic [15:0] fn_rand;
  logic [2:0]  lanes_r;

  initial begin
    reset_i = 1'b1; enable_i = 1'b1; active_lanes_i = 3'd4; vc_select_i = 2'd0;
    hdr_valid_i = 1'b0; hdr_data_id_i = '0; hdr_word_count_i = '0;
    hdr_ecc_err_i = 1'b0; hdr_ecc_corr_i = 1'b0; payload_valid_i = 1'b0;
    payload_bytes_i = '0; crc_done_i = 1'b0; crc_err_i = 1'b0; eot_i = 1'b0;
    m_fv = 0; m_lv = 0; m_fn = 0; m_ln = 0; m_ecc = 0; m_crc = 0; m_dt = 0; m_vc_sel = 0;
    repeat (3) @(negedge clk_i);

    // Reset state.
    chk("rst_payload_en", 32'(payload_en_o), 32'd0);
    chk("rst_pixel_dt",   32'(pixel_dt_o),   32'd0);
    chk("rst_pkt_done",   32'(pkt_done_o),   32'd0);
    chk("rst_errs", 32'({err_ecc_o, err_crc_o, err_sync_o, err_trunc_o}), 32'd0);
    chk("rst_ecc_cnt",    32'(err_ecc_cnt_o), 32'd0);
    chk("rst_crc_cnt",    32'(err_crc_cnt_o), 32'd0);
    check_frame("rst");
    reset_i = 1'b0;

    // FS then a 4-lane packet with 4+1 byte beats, good and bad CRC.
    do_hdr(2'd0, 6'h00, 16'd7, 1'b0, 1'b0);
    send_long(3'd4, 6'h2A, 16'd5, 3'd4, 1'b0);
    finish_crc(1'b0);
    send_long(3'd4, 6'h2A, 16'd5, 3'd4, 1'b0);
    finish_crc(1'b1);

    // One and two lanes.
    send_long(3'd1, 6'h2B, 16'd5, 3'd1, 1'b0);
    finish_crc(1'b0);
    send_long(3'd2, 6'h2C, 16'd5, 3'd2, 1'b0);
    finish_crc(1'b0);

    // Uncorrectable ECC: skip until eot, payload gated off.
    do_hdr(2'd0, 6'h2A, 16'd10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) beat(3'd2, 1'b0, 1'b0, 1'b0);
    end_beats();
    @(negedge clk_i); crc_done_i = 1'b1;
    @(negedge clk_i); crc_done_i = 1'b0;
    chk("skip_no_pkt_done", 32'(pkt_done_o), 32'd0);
    do_eot(1'b0);
    do_hdr(2'd0, 6'h02, 16'd0, 1'b0, 1'b0);
    do_hdr(2'd0, 6'h03, 16'd0, 1'b0, 1'b0);

    // Corrected ECC still delivers the packet.
    send_long(3'd4, 6'h24, 16'd3, 3'd0, 1'b1);
    finish_crc(1'b0);

    // FE then FE without FS; LS outside a frame.
    do_hdr(2'd0, 6'h01, 16'd0, 1'b0, 1'b0);
    do_hdr(2'd0, 6'h01, 16'd0, 1'b0, 1'b0);
    do_hdr(2'd0, 6'h02, 16'd0, 1'b0, 1'b0);

    // FS twice.
    do_hdr(2'd0, 6'h00, 16'd3, 1'b0, 1'b0);
    send_long(3'd4, 6'h2A, 16'd2, 3'd0, 1'b0);
    finish_crc(1'b0);
    fn_rand = 16'($urandom_range(0, 65535));
    do_hdr(2'd0, 6'h00, fn_rand, 1'b0, 1'b0);

    // Truncation mid-payload with a line open.
    do_hdr(2'd0, 6'h02, 16'd0, 1'b0, 1'b0);
    active_lanes_i = 3'd4;
    do_hdr(2'd0, 6'h2A, 16'd8, 1'b0, 1'b0);
    beat(3'd4, 1'b0, 1'b1, 1'b0);
    end_beats();
    do_eot(1'b1);
    drop_expected();
    chk("trunc_payload_en", 32'(payload_en_o), 32'd0);

    // eot arriving with the final beat, and eot while awaiting CRC.
    do_hdr(2'd0, 6'h02, 16'd0, 1'b0, 1'b0);
    do_hdr(2'd0, 6'h2A, 16'd4, 1'b0, 1'b0);
    @(negedge clk_i);
    payload_valid_i = 1'b1; payload_bytes_i = 3'd4; eot_i = 1'b1;
    end_beats();
    m_lv = 1'b0;
    chk("trunc_last_beat", 32'(err_trunc_o), 32'd1);
    chk("trunc_last_no_done", 32'(pkt_done_o), 32'd0);
    check_frame("trunc_last");
    drop_expected();
    do_hdr(2'd0, 6'h2A, 16'd0, 1'b0, 1'b0);
    do_eot(1'b1);
    drop_expected();

    // Foreign virtual channel.
    do_hdr(2'd1, 6'h2A, 16'd4, 1'b0, 1'b0);
    beat(3'd4, 1'b0, 1'b0, 1'b0);
    end_beats();
    @(negedge clk_i); crc_done_i = 1'b1;
    @(negedge clk_i); crc_done_i = 1'b0;
    chk("vc_drop_no_pkt_done", 32'(pkt_done_o), 32'd0);
    do_eot(1'b0);
    do_hdr(2'd1, 6'h01, 16'd0, 1'b0, 1'b0);

    // Disable mid-packet: return to header wait, frame state held, input dropped.
    do_hdr(2'd0, 6'h02, 16'd0, 1'b0, 1'b0);
    do_hdr(2'd0, 6'h30, 16'd8, 1'b0, 1'b0);
    beat(3'd4, 1'b0, 1'b1, 1'b0);
    @(negedge clk_i);
    payload_valid_i = 1'b0; enable_i = 1'b0;
    hdr_valid_i = 1'b1; hdr_data_id_i = {2'd0, 6'h01};
    #1 chk("dis_payload_en", 32'(payload_en_o), 32'd0);
    @(negedge clk_i);
    hdr_valid_i = 1'b0; enable_i = 1'b1;
    chk("dis_err_sync", 32'(err_sync_o), 32'd0);
    check_frame("dis");
    drop_expected();
    beat(3'd4, 1'b0, 1'b0, 1'b0);
    end_beats();
    send_long(3'd4, 6'h2A, 16'd6, 3'd0, 1'b0);
    finish_crc(1'b0);

    // Randomized mix of short and long packets.
    for (int it = 0; it < 30; it++) begin
      m_vc_sel = 2'($urandom_range(0, 3));
      vc_select_i = m_vc_sel;
      if ($urandom_range(0, 2) == 0) begin
        do_hdr(m_vc_sel, 6'($urandom_range(0, 4)), 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
      end else begin
        case ($urandom_range(0, 2))
          0:       lanes_r = 3'd1;
          1:       lanes_r = 3'd2;
          default: lanes_r = 3'd4;
        endcase
        send_long(lanes_r, 6'($urandom_range(16, 63)), 16'($urandom_range(0, 12)), 3'd0,
                  1'($urandom_range(0, 1)));
        finish_crc(1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mipi_csi_rx_packet_ctrl.md
Name: mipi_csi_rx_packet_ctrl

Overview:
- Packet-level sequencer for the CSI-2 RX protocol layer.
- Consumes decoded packet headers (data ID, word count, ECC status), payload-beat strobes and CRC results from the protocol layer.
- Gates payload acceptance, marks the last payload beat, and tracks frame/line state from short packets (FS/FE/LS/LE).
- Filters by virtual channel and counts errors; sits between lane merging/protocol layer and the pixel unpacker.

Parameters:
- ERR_CNT_W, 16, width of each saturating error counter.
- TIMEOUT_CYCLES, 4096, watchdog limit in cycles without progress (used only with the optional feature).

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous, active-high reset.
- enable_i  input  1  0 forces WAIT_HDR and drops all input.
- active_lanes_i  input  3  1, 2 or 4; caps bytes per beat.
- vc_select_i  input  2  accepted virtual channel.
- hdr_valid_i  input  1  one-cycle header strobe.
- hdr_data_id_i  input  8  [7:6] VC, [5:0] data type.
- hdr_word_count_i  input  16  payload bytes (long packet), or frame/line number (short packet).
- hdr_ecc_err_i  input  1  uncorrectable ECC error.
- hdr_ecc_corr_i  input  1  single-bit ECC error corrected.
- payload_valid_i  input  1  payload beat strobe.
- payload_bytes_i  input  3  bytes in the beat, 1..active_lanes_i.
- crc_done_i  input  1  CRC check complete.
- crc_err_i  input  1  CRC mismatch; qualified by crc_done_i.
- eot_i  input  1  end-of-transmission from the lane layer.
- payload_en_o  output  1  downstream should consume payload.
- payload_last_o  output  1  last payload beat of the packet.
- pixel_dt_o  output  6  data type of the current long packet.
- frame_valid_o  output  1  frame active.
- line_valid_o  output  1  line active.
- frame_num_o  output  16  frame number from the FS word count.
- line_num_o  output  16  line index within the frame.
- pkt_done_o  output  1  pulse when a long packet completes.
- err_ecc_o, err_crc_o, err_sync_o, err_trunc_o  output  1 each  one-cycle error pulses.
- err_ecc_cnt_o, err_crc_cnt_o  output  ERR_CNT_W each  saturating counters.

Behaviour:
- Reset: state=WAIT_HDR; every output 0.
- States: WAIT_HDR, PAYLOAD, CRC_WAIT, SKIP.
- WAIT_HDR, on hdr_valid_i:
  - hdr_ecc_err_i=1 -> pulse err_ecc, go to SKIP.
  - VC != vc_select_i -> long packet goes to SKIP; short packet is ignored.
  - Short packet (DT < 0x10):
    - FS (0x00): if frame_valid_o=1, pulse err_sync first. Then frame_valid_o=1, frame_num_o=WC, line_num_o=0.
    - FE (0x01): if frame_valid_o=0, pulse err_sync. Clear frame_valid_o and line_valid_o.
    - LS (0x02): if no frame is active, pulse err_sync; otherwise set line_valid_o.
    - LE (0x03): clear line_valid_o.
    - Other short types: ignored.
  - Long packet: latch WC into remaining, pixel_dt_o=DT. Go to PAYLOAD, or to CRC_WAIT if WC=0.
- Timing: outputs update one cycle after the triggering strobe.
- PAYLOAD:
  - payload_en_o=1.
  - Each beat subtracts min(payload_bytes_i, remaining) from remaining.
  - payload_last_o is asserted combinationally on the beat where payload_bytes_i >= remaining; next state is CRC_WAIT.
  - payload_bytes_i > active_lanes_i is clamped to active_lanes_i.
- CRC_WAIT, on crc_done_i:
  - Pulse pkt_done_o; if crc_err_i, pulse err_crc.
  - If frame_valid_o=1, line_num_o += 1 (wraps at 16 bits).
  - Go to WAIT_HDR.
- SKIP: payload_en_o=0; leave on eot_i.
- eot_i in PAYLOAD or CRC_WAIT: pulse err_trunc, clear line_valid_o, go to WAIT_HDR.
- Simultaneous events:
  - eot_i together with the final payload beat counts as truncation.
  - hdr_valid_i outside WAIT_HDR is ignored.
- Counters:
  - err_ecc_cnt_o counts ECC errors (uncorrectable and corrected); err_crc_cnt_o counts CRC errors.
  - Both saturate at all-ones and clear only on reset.
- enable_i=0 mid-packet: return to WAIT_HDR next cycle; frame/line state is held.

Optional Feature:
- MIPI_CSI_RX_PKT_TIMEOUT_EN defined:
  - A watchdog counts cycles in PAYLOAD/CRC_WAIT/SKIP without payload_valid_i or crc_done_i.
  - At TIMEOUT_CYCLES: pulse err_trunc, force WAIT_HDR, clear line_valid_o.
- Undefined: no watchdog logic; the FSM can wait indefinitely.

Decomposition:
- Package mipi_csi_rx_pkg holds:
  - Data-type constants DT_FS/DT_FE/DT_LS/DT_LE and SHORT_PKT_MAX=0x0F.
  - The FSM state enum.
  - The data-ID field slicing constants.
- Sub-module mipi_csi_rx_sat_counter (parameterised width, increment, saturate), instantiated twice.

Test Plan:
- 4 lanes: FS WC=7, then long DT=0x2A WC=5, beats of 4 then 1 bytes, crc_done with no error.
  - frame_valid_o=1, frame_num_o=7.
  - payload_last_o on the second beat.
  - pkt_done_o pulse; line_num_o=1.
- Same packet with crc_err_i=1 -> err_crc pulse, err_crc_cnt_o=1; the FSM returns to WAIT_HDR.
- 1 lane, WC=5: five 1-byte beats -> payload_last_o on the 5th beat. 2 lanes, WC=5: beats 2,2,1 -> last on the 3rd beat.
- Header with hdr_ecc_err_i=1 -> err_ecc pulse, SKIP, payload_en_o=0 until eot_i.
- FE without FS -> err_sync pulse.
- FS, then FS again -> err_sync pulse, frame_num_o updated, line_num_o=0.
- Long packet WC=8, eot_i after 4 bytes -> err_trunc pulse, WAIT_HDR.
- VC=1 with vc_select_i=0 -> packet dropped, no pkt_done_o.
